// File: rtl/matrix_keypad_scanner.sv
// Parametrised ROWS x COLS matrix keypad scanner.
// Scans columns on a clock-enable tick, debounces press and release, and
// optionally emits auto-repeat events while a key stays held.
// Note: reset_n is active-high despite its name (async, posedge).
module matrix_keypad_scanner #(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int CLK_DIV      = 50,
  parameter int DEBOUNCE     = 8,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100,
  parameter int CODE_W       = $clog2(ROWS*COLS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ROWS-1:0]   row,
  output logic [COLS-1:0]   col,
  output logic              key_valid,
  output logic [CODE_W-1:0] key_code,
  output logic              key_pressed,
  output logic              key_repeat
);

  localparam int RI_W   = $clog2(ROWS);
  localparam int CI_W   = $clog2(COLS);
  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam int DCNT_W = $clog2(DEBOUNCE + 1);
  localparam int RMAX   = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RCNT_W = $clog2(RMAX + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CI_W-1:0]   COL_LAST = CI_W'(COLS - 1);
  localparam logic [DCNT_W-1:0] DEB_CNT  = DCNT_W'(DEBOUNCE);
  localparam logic [RCNT_W-1:0] RDLY_CNT = RCNT_W'(REPEAT_DELAY);
  localparam logic [RCNT_W-1:0] RATE_CNT = RCNT_W'(REPEAT_RATE);
  localparam logic [COLS-1:0]   COL_ONE  = COLS'(1);

  typedef enum logic [1:0] {IDLE, SCAN, DEB_P, HELD} state_t;

  state_t            state, state_nx;
  logic [ROWS-1:0]   row_meta, rs;
  logic [DIV_W-1:0]  div_cnt;
  logic              tick;
  logic              any_row;
  logic [RI_W-1:0]   low_row;
  logic [CODE_W-1:0] code_calc;

  logic [CI_W-1:0]   ci, ci_nx;
  logic [RI_W-1:0]   ri, ri_nx;
  logic [DCNT_W-1:0] dcnt, dcnt_nx;
  logic [DCNT_W-1:0] relcnt, relcnt_nx;
  logic [RCNT_W-1:0] rcnt, rcnt_nx;
  logic              rep_phase, rep_phase_nx;
  logic              key_valid_nx, key_repeat_nx, key_pressed_nx;
  logic [CODE_W-1:0] key_code_nx;

  // Two-flop synchroniser for the asynchronous row pins, idling high.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      row_meta <= '1;
      rs       <= '1;
    end else begin
      row_meta <= row;
      rs       <= row_meta;
    end
  end

  assign tick = (div_cnt == DIV_LAST);

  // Free-running divider producing a one-clk scan tick every CLK_DIV cycles.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign any_row   = ~&rs;
  assign code_calc = CODE_W'(ri) * CODE_W'(COLS) + CODE_W'(ci);

  // Lowest-indexed active row wins arbitration within a column.
  always_comb begin
    low_row = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (!rs[i]) low_row = RI_W'(i);
    end
  end

  // Column drive: all columns low while idle, otherwise only the selected one.
  always_comb begin
    col = '1;
    if (state == IDLE) col = '0;
    else               col = ~(COL_ONE << ci);
  end

  // Next-state and output decode; everything advances only on a scan tick.
  always_comb begin
    state_nx       = state;
    ci_nx          = ci;
    ri_nx          = ri;
    dcnt_nx        = dcnt;
    relcnt_nx      = relcnt;
    rcnt_nx        = rcnt;
    rep_phase_nx   = rep_phase;
    key_code_nx    = key_code;
    key_pressed_nx = key_pressed;
    key_valid_nx   = 1'b0;
    key_repeat_nx  = 1'b0;
    if (tick) begin
      case (state)
        IDLE: begin
          if (any_row) begin
            ci_nx    = '0;
            state_nx = SCAN;
          end
        end
        SCAN: begin
          if (any_row) begin
            ri_nx    = low_row;
            dcnt_nx  = '0;
            state_nx = DEB_P;
          end else if (ci == COL_LAST) begin
            state_nx = IDLE;
          end else begin
            ci_nx = ci + 1'b1;
          end
        end
        DEB_P: begin
          if (!rs[ri]) begin
            if (dcnt + 1'b1 == DEB_CNT) begin
              key_valid_nx   = 1'b1;
              key_code_nx    = code_calc;
              key_pressed_nx = 1'b1;
              rcnt_nx        = '0;
              rep_phase_nx   = 1'b0;
              relcnt_nx      = '0;
              state_nx       = HELD;
            end else begin
              dcnt_nx = dcnt + 1'b1;
            end
          end else begin
            state_nx = IDLE;
          end
        end
        HELD: begin
          if (rs[ri]) begin
            if (relcnt + 1'b1 == DEB_CNT) begin
              key_pressed_nx = 1'b0;
              state_nx       = IDLE;
            end else begin
              relcnt_nx = relcnt + 1'b1;
            end
          end else begin
            relcnt_nx = '0;
            if (REPEAT_DELAY > 0) begin
              if (rcnt + 1'b1 == (rep_phase ? RATE_CNT : RDLY_CNT)) begin
                key_valid_nx  = 1'b1;
                key_repeat_nx = 1'b1;
                rcnt_nx       = '0;
                rep_phase_nx  = 1'b1;
              end else begin
                rcnt_nx = rcnt + 1'b1;
              end
            end
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // State register plus registered outputs, all cleared asynchronously.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state       <= IDLE;
      ci          <= '0;
      ri          <= '0;
      dcnt        <= '0;
      relcnt      <= '0;
      rcnt        <= '0;
      rep_phase   <= 1'b0;
      key_valid   <= 1'b0;
      key_repeat  <= 1'b0;
      key_code    <= '0;
      key_pressed <= 1'b0;
    end else begin
      state       <= state_nx;
      ci          <= ci_nx;
      ri          <= ri_nx;
      dcnt        <= dcnt_nx;
      relcnt      <= relcnt_nx;
      rcnt        <= rcnt_nx;
      rep_phase   <= rep_phase_nx;
      key_valid   <= key_valid_nx;
      key_repeat  <= key_repeat_nx;
      key_code    <= key_code_nx;
      key_pressed <= key_pressed_nx;
    end
  end

endmodule

// File: tb/tb_matrix_keypad_scanner.sv
// Self-checking bench for matrix_keypad_scanner with a behavioural keypad
// and an arithmetic timing model of press, repeat and release events.
module tb_matrix_keypad_scanner;

  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int DIV    = 4;
  localparam int DEB    = 3;
  localparam int RDELAY = 10;
  localparam int RRATE  = 4;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [ROWS-1:0] row;
  logic [COLS-1:0] col;
  logic            key_valid;
  logic [3:0]      key_code;
  logic            key_pressed;
  logic            key_repeat;

  logic [ROWS*COLS-1:0] pressed;

  typedef struct {
    int   t;
    int   code;
    logic rep;
  } ev_t;

  ev_t evq[$];
  int  cyc;
  int  rep_glitch = 0;
  int  errors = 0;
  int  checks = 0;

  matrix_keypad_scanner #(
    .ROWS(ROWS), .COLS(COLS), .CLK_DIV(DIV), .DEBOUNCE(DEB),
    .REPEAT_DELAY(RDELAY), .REPEAT_RATE(RRATE)
  ) dut (
    .clk(clk), .reset_n(reset_n), .row(row), .col(col),
    .key_valid(key_valid), .key_code(key_code),
    .key_pressed(key_pressed), .key_repeat(key_repeat)
  );

  always #5 clk = ~clk;

  // Keypad: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (pressed[r*COLS+c] && !col[c]) row[r] = 1'b0;
  end

  // Clock edges counted since the last reset release.
  always @(posedge clk or posedge reset_n) begin
    if (reset_n) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  // Record every key_valid cycle just after the edge that produced it.
  always @(posedge clk) begin
    ev_t e;
    #1;
    if (key_valid === 1'b1) begin
      e.t = cyc; e.code = int'(key_code); e.rep = key_repeat;
      evq.push_back(e);
    end else if (key_repeat !== 1'b0) begin
      rep_glitch++;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: time limit reached, observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  // First tick edge whose sample sees a row change made just after edge n.
  function automatic int nte(input int n);
    return ((n + 3 + DIV - 1) / DIV) * DIV;
  endfunction

  // Edge at which a clean press of a key in column c is reported.
  function automatic int press_edge(input int n, input int c);
    return nte(n) + DIV * (1 + c + DEB);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int r, input int c, input logic down);
    pressed[r*COLS+c] = down;
  endtask

  task automatic wait_cyc(input int target);
    int k = 0;
    while (cyc < target && k < 20000) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic wait_events(input int n, input int budget);
    int k = 0;
    while (evq.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic wait_released(input string tag);
    int k = 0;
    while (key_pressed !== 1'b0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    checkOutput(tag, key_pressed, 0);
  endtask

  task automatic check_all_reset(input string tag);
    checkOutput({tag, "_col"}, col, 0);
    checkOutput({tag, "_valid"}, key_valid, 0);
    checkOutput({tag, "_code"}, key_code, 0);
    checkOutput({tag, "_pressed"}, key_pressed, 0);
    checkOutput({tag, "_repeat"}, key_repeat, 0);
  endtask

  initial begin
    int n, e1, expv, t0, x, k;
    pressed = '0;
    reset_n = 1'b1;
    @(negedge clk);
    check_all_reset("reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b0;

    // Clean press of (2,1) with exact latency and release behaviour.
    repeat ($urandom_range(2, 9)) @(negedge clk);
    evq.delete();
    n = cyc;
    applyStimulus(2, 1, 1'b1);
    expv = press_edge(n, 1);
    wait_events(1, 200);
    checkOutput("s1_count", evq.size(), 1);
    if (evq.size() > 0) begin
      checkOutput("s1_code", evq[0].code, 9);
      checkOutput("s1_rep", evq[0].rep, 0);
      checkOutput("s1_time", evq[0].t, expv);
    end
    checkOutput("s1_pressed", key_pressed, 1);
    wait_cyc(expv + DIV * 5 + int'($urandom_range(0, 3)));
    n = cyc;
    applyStimulus(2, 1, 1'b0);
    e1 = nte(n);
    wait_cyc(e1 + DIV * (DEB - 2));
    checkOutput("s1_still_held", key_pressed, 1);
    wait_cyc(e1 + DIV * DEB);
    checkOutput("s1_released", key_pressed, 0);
    checkOutput("s1_no_extra", evq.size(), 1);

    // Sweep all keys in order with random start phase and hold time.
    for (int kk = 0; kk < ROWS * COLS; kk++) begin
      repeat ($urandom_range(1, 8)) @(negedge clk);
      evq.delete();
      n = cyc;
      applyStimulus(kk / COLS, kk % COLS, 1'b1);
      expv = press_edge(n, kk % COLS);
      wait_events(1, 200);
      wait_cyc(expv + DIV * int'($urandom_range(1, 6)));
      applyStimulus(kk / COLS, kk % COLS, 1'b0);
      wait_released($sformatf("sweep_rel_%0d", kk));
      checkOutput($sformatf("sweep_count_%0d", kk), evq.size(), 1);
      if (evq.size() > 0) begin
        checkOutput($sformatf("sweep_code_%0d", kk), evq[0].code, kk);
        checkOutput($sformatf("sweep_time_%0d", kk), evq[0].t, expv);
      end
    end

    // Press (0,3) with one high sample during debounce.
    repeat ($urandom_range(1, 8)) @(negedge clk);
    evq.delete();
    n = cyc;
    applyStimulus(0, 3, 1'b1);
    t0 = nte(n);
    x = t0 + DIV * (1 + 3) + DIV * 2;
    wait_cyc(x - 3);
    applyStimulus(0, 3, 1'b0);
    wait_cyc(x - 2);
    applyStimulus(0, 3, 1'b1);
    expv = x + DIV + DIV * (1 + 3 + DEB);
    wait_events(1, 300);
    checkOutput("bounce_count", evq.size(), 1);
    if (evq.size() > 0) begin
      checkOutput("bounce_code", evq[0].code, 3);
      checkOutput("bounce_time", evq[0].t, expv);
    end
    applyStimulus(0, 3, 1'b0);
    wait_released("bounce_rel");
    checkOutput("bounce_no_extra", evq.size(), 1);

    // Long hold of (3,3): initial event plus five repeats.
    repeat ($urandom_range(1, 8)) @(negedge clk);
    evq.delete();
    n = cyc;
    applyStimulus(3, 3, 1'b1);
    expv = press_edge(n, 3);
    wait_cyc(expv + DIV * 28);
    applyStimulus(3, 3, 1'b0);
    wait_released("hold_rel");
    checkOutput("hold_count", evq.size(), 6);
    k = (evq.size() < 6) ? evq.size() : 6;
    for (int i = 0; i < k; i++) begin
      checkOutput($sformatf("hold_code_%0d", i), evq[i].code, 15);
      checkOutput($sformatf("hold_rep_%0d", i), evq[i].rep, (i > 0) ? 1 : 0);
      checkOutput($sformatf("hold_time_%0d", i), evq[i].t,
                  (i == 0) ? expv : expv + DIV * (RDELAY + RRATE * (i - 1)));
    end

    // Hold (1,0), add (1,2) and (0,0), then release (1,0).
    repeat ($urandom_range(1, 8)) @(negedge clk);
    evq.delete();
    n = cyc;
    applyStimulus(1, 0, 1'b1);
    expv = press_edge(n, 0);
    wait_events(1, 200);
    wait_cyc(expv + DIV);
    applyStimulus(1, 2, 1'b1);
    applyStimulus(0, 0, 1'b1);
    wait_cyc(expv + DIV * 3);
    applyStimulus(1, 0, 1'b0);
    wait_events(2, 300);
    applyStimulus(1, 2, 1'b0);
    applyStimulus(0, 0, 1'b0);
    wait_released("multi_rel");
    checkOutput("multi_count", evq.size(), 2);
    if (evq.size() > 1) begin
      checkOutput("multi_first", evq[0].code, 4);
      checkOutput("multi_second", evq[1].code, 0);
      checkOutput("multi_second_rep", evq[1].rep, 0);
    end

    // Reset while HELD on (3,1), then restart with the key still down.
    repeat ($urandom_range(1, 8)) @(negedge clk);
    evq.delete();
    n = cyc;
    applyStimulus(3, 1, 1'b1);
    expv = press_edge(n, 1);
    wait_events(1, 200);
    wait_cyc(expv + DIV * 2);
    checkOutput("held_code", key_code, 13);
    checkOutput("held_pressed", key_pressed, 1);
    #2;
    reset_n = 1'b1;
    #1;
    check_all_reset("held_reset");
    repeat (2) @(negedge clk);
    evq.delete();
    reset_n = 1'b0;
    wait_events(1, 200);
    checkOutput("restart_count", evq.size(), 1);
    if (evq.size() > 0) begin
      checkOutput("restart_code", evq[0].code, 13);
      checkOutput("restart_time", evq[0].t, press_edge(0, 1));
    end
    applyStimulus(3, 1, 1'b0);
    wait_released("restart_rel");

    // Reset while debouncing (2,2); no event may follow.
    repeat ($urandom_range(1, 8)) @(negedge clk);
    evq.delete();
    n = cyc;
    applyStimulus(2, 2, 1'b1);
    t0 = nte(n);
    wait_cyc(t0 + DIV * 3 + 2);
    checkOutput("debp_col", col, 4'b1011);
    #2;
    reset_n = 1'b1;
    #1;
    check_all_reset("debp_reset");
    applyStimulus(2, 2, 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    repeat (60) @(negedge clk);
    checkOutput("debp_no_event", evq.size(), 0);
    checkOutput("debp_idle_col", col, 0);

    checkOutput("repeat_without_valid", rep_glitch, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/matrix_keypad_scanner.md
# matrix_keypad_scanner

Parametrised ROWS×COLS matrix keypad scanner. It is the successor to the fixed 4×4 scanner and runs entirely in the `clk` domain, using a clock-enable scan tick instead of a derived clock. It adds row synchronisation, press and release debounce, and optional auto-repeat. It sits between the board keypad pins and the clock-setting control logic, which consumes `key_valid`/`key_code`.

## Interface
Parameters:
- `ROWS`, 4: number of row inputs (≥2).
- `COLS`, 4: number of column outputs (≥2).
- `CLK_DIV`, 50: `clk` cycles per scan tick (≥4).
- `DEBOUNCE`, 8: consecutive ticks required to accept a press or a release (≥1).
- `REPEAT_DELAY`, 500: ticks held before the first repeat; 0 disables auto-repeat.
- `REPEAT_RATE`, 100: ticks between subsequent repeats (≥1).
- `CODE_W`, $clog2(ROWS*COLS): key code width.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: system clock, 50 MHz.
- `reset_n` in 1: asynchronous, active-high reset.
- `row` in ROWS: row sense lines, active-low, externally pulled up.
- `col` out COLS: column drive, active-low.
- `key_valid` out 1: one-`clk` pulse per accepted press or repeat.
- `key_code` out CODE_W: row_idx*COLS + col_idx. Row0/col0 = 0, row0/col1 = 1.
- `key_pressed` out 1: level, high while a debounced key is held.
- `key_repeat` out 1: qualifies `key_valid`. 1 = auto-repeat event, 0 = initial press.

## Operation
- `row` passes through a 2-FF synchroniser. All decisions use the synchronised value `rs`.
- Tick generator: counter runs 0..CLK_DIV-1. `tick` is high for one `clk` when counter = CLK_DIV-1. The FSM advances only on `tick`.
- **IDLE**: `col` = all 0. On a tick with `rs` ≠ all 1: set ci = 0, `col` = ~(1<<0), go to SCAN.
- **SCAN**: `col` has only bit ci low.
  - On a tick with `rs` ≠ all 1: capture ri = lowest index with `rs[ri]`=0, capture ci, set dcnt = 0, go to DEB_P.
  - Otherwise, if ci = COLS-1: go to IDLE.
  - Otherwise: ci++ and drive the next column.
- **DEB_P**: `col` is held on ci. On each tick:
  - `rs[ri]`=0: dcnt++. When dcnt reaches DEBOUNCE, pulse `key_valid` with `key_repeat`=0, latch `key_code`, set `key_pressed`=1, clear rcnt, go to HELD.
  - `rs[ri]`=1: go to IDLE (bounce; no output).
- **HELD**: `col` is held on ci. On each tick:
  - `rs[ri]`=1: relcnt++. When relcnt reaches DEBOUNCE, set `key_pressed`=0 and go to IDLE.
  - `rs[ri]`=0: relcnt = 0 and rcnt++.
  - Repeat (only if REPEAT_DELAY>0): when rcnt = REPEAT_DELAY, and then every REPEAT_RATE ticks after that, pulse `key_valid` with `key_repeat`=1 and the same `key_code`.
- Only the captured (ri, ci) is monitored after capture. Additional keys pressed while one is held are ignored. A row that lost arbitration is not reported. Ghosting is not resolved.
- Multiple rows low in the same column: the lowest row index wins. Multiple columns: the first scanned column wins.
- Codes are decoded arithmetically; no lookup table. `key_code` holds its value until the next `key_valid`.

## Timing
- Reset values: `col` all 0, `key_valid` 0, `key_code` 0, `key_pressed` 0, `key_repeat` 0. FSM in IDLE, all counters 0, synchroniser flops 1.
- Reset asserted mid-operation: all outputs return to their reset values immediately and asynchronously. No `key_valid` is produced for the interrupted press.
- `key_valid` and `key_repeat` change on the `clk` edge following the deciding tick and last exactly 1 `clk`. `key_repeat` is 0 whenever `key_valid` is 0.
- `key_pressed` rises in the same cycle as the initial `key_valid`.
- `col` changes only on tick edges. Rows are next sampled one full tick (CLK_DIV clk) after a change, which allows settling.
- Press latency, with IDLE detecting the press at tick T0 and the key in column c: capture at tick T0+1+c, `key_valid` at tick T0+1+c+DEBOUNCE. Add 2 `clk` of synchroniser lag.
- Release latency: `key_pressed` falls DEBOUNCE ticks after the first tick seeing `rs[ri]`=1, provided that sampling is unbroken.
- Counter widths are sized for their maximum values (DEBOUNCE, REPEAT_DELAY, REPEAT_RATE, CLK_DIV) and never wrap.

## Test plan
Bench settings: ROWS=4, COLS=4, CLK_DIV=4, DEBOUNCE=3, REPEAT_DELAY=10, REPEAT_RATE=4. The keypad model drives `row[r]`=0 when key (r,c) is pressed and `col[c]`=0.
- Reset, then press (2,1) cleanly → one `key_valid`, `key_code`=9, `key_repeat`=0, 2+3 ticks after IDLE detection. `key_pressed`=1 until 3 ticks after release.
- Sweep all 16 keys, one at a time → codes 0..15 in order, exactly one `key_valid` each, no repeats if each key is held for fewer than 10 ticks.
- Press (0,3) with bounce of 1 high tick inside the debounce window → no `key_valid` until 3 consecutive low ticks, then exactly one pulse with code 3.
- Hold (3,3) for 30 ticks → initial pulse, then `key_repeat`=1 pulses at rcnt 10, 14, 18, 22, 26, all with code 15.
- Hold (1,0), then also press (1,2) and (0,0) → only code 4 reported. After (1,0) is released, the remaining held key is rescanned and reported on the new press; with (0,0) and (1,2) both still held, code 0 is reported (first column scanned).
- Assert `reset_n` mid-DEB_P and mid-HELD → outputs go to reset values asynchronously, no spurious pulse. After release of reset, the FSM restarts from IDLE.
